// File: rtl/noise_channel_pkg.sv
// Shared definitions for the sound voices and the mixer.
//   SAMPLE_W  : width of a voice volume / sample
//   LEN_MAX   : length-counter full scale (counter loads LEN_MAX - lenLoad)
//   LEN_W     : length-counter width, wide enough to hold LEN_MAX itself
//   DIV_W     : noise divider counter width
//   LFSR_W    : noise LFSR width
//   div_base  : noise divisor code -> base period in clk cycles
//   rise_edge : rising-edge detect of a slow frame tick sampled in the clk domain
package noise_channel_pkg;

  localparam int SAMPLE_W = 4;
  localparam int LEN_MAX  = 64;
  localparam int LEN_W    = 7;
  localparam int DIV_W    = 22;
  localparam int LFSR_W   = 15;

  function automatic logic [6:0] div_base(input logic [2:0] code);
    logic [6:0] base;
    case (code)
      3'd0:    base = 7'd8;
      3'd1:    base = 7'd16;
      3'd2:    base = 7'd32;
      3'd3:    base = 7'd48;
      3'd4:    base = 7'd64;
      3'd5:    base = 7'd80;
      3'd6:    base = 7'd96;
      default: base = 7'd112;
    endcase
    return base;
  endfunction

  function automatic logic rise_edge(input logic prev, input logic cur);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/noise_channel_length_counter.sv
// Generic voice length counter: loads on trigger, counts down on each frame
// tick while enabled, sticks at zero.
//   clk, rst  : clock, async active-high reset
//   tick      : one-clk frame tick pulse
//   enable    : count enable
//   load      : trigger strobe, wins over a same-cycle tick
//   load_val  : value loaded on trigger
//   expire    : one-clk pulse on the cycle the counter goes 1 -> 0
module noise_channel_length_counter
  import noise_channel_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             enable,
  input  logic             load,
  input  logic [LEN_W-1:0] load_val,
  output logic             expire
);

  logic [LEN_W-1:0] count;

  assign expire = ~load & tick & enable & (count == LEN_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && enable && count != '0) begin
      count <= count - LEN_W'(1);
    end
  end

endmodule

// File: rtl/noise_channel.sv
// Noise voice: LFSR clocked by a programmable divider, output gated by the
// inverted LFSR LSB and scaled by a 64 Hz volume envelope; 256 Hz length
// counter shuts the voice off.
//   clk, rst          : 4.194304 MHz clock, async active-high reset
//   clk256, clk64     : frame tick levels, rising edges detected here
//   lenLoad/lenEnable : length load value and enable
//   startVol/envAdd/period : envelope initial volume, direction, step period
//   clkShift/divisor/widthMode : LFSR clock divider and short-mode select
//   trigger           : one-clk restart strobe
//   out               : registered 4-bit sample
module noise_channel
  import noise_channel_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clk256,
  input  logic                clk64,
  input  logic [5:0]          lenLoad,
  input  logic [SAMPLE_W-1:0] startVol,
  input  logic                envAdd,
  input  logic [2:0]          period,
  input  logic [3:0]          clkShift,
  input  logic                widthMode,
  input  logic [2:0]          divisor,
  input  logic                trigger,
  input  logic                lenEnable,
  output logic [SAMPLE_W-1:0] out
);

  logic                clk256_q, clk64_q;
  logic                tick256, tick64;
  logic                dac_en, enabled, len_expire;
  logic [SAMPLE_W-1:0] volume;
  logic [2:0]          env_timer;
  logic [DIV_W-1:0]    div_cnt, div_reload;
  logic [LFSR_W-1:0]   lfsr, lfsr_next;
  logic                lfsr_fb, lfsr_run;

  assign tick256    = rise_edge(clk256_q, clk256);
  assign tick64     = rise_edge(clk64_q, clk64);
  assign dac_en     = (startVol != '0) | envAdd;
  assign div_reload = DIV_W'(div_base(divisor)) << clkShift;
  assign lfsr_run   = clkShift < 4'd14;

  always_comb begin
    lfsr_fb   = lfsr[0] ^ lfsr[1];
    lfsr_next = {lfsr_fb, lfsr[LFSR_W-1:1]};
    if (widthMode) lfsr_next[6] = lfsr_fb;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk256_q <= 1'b0;
      clk64_q  <= 1'b0;
    end else begin
      clk256_q <= clk256;
      clk64_q  <= clk64;
    end
  end

  noise_channel_length_counter u_len (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick256),
    .enable   (lenEnable),
    .load     (trigger),
    .load_val (LEN_W'(LEN_MAX) - LEN_W'(lenLoad)),
    .expire   (len_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             enabled <= 1'b0;
    else if (!dac_en)    enabled <= 1'b0;
    else if (trigger)    enabled <= 1'b1;
    else if (len_expire) enabled <= 1'b0;
  end

  // A timer of 0 (never triggered) is treated like 1 so the first tick steps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      volume    <= '0;
      env_timer <= '0;
    end else if (trigger) begin
      volume    <= startVol;
      env_timer <= period;
    end else if (tick64 && period != '0) begin
      if (env_timer <= 3'd1) begin
        env_timer <= period;
        if (envAdd && volume != 4'd15)     volume <= volume + 4'd1;
        else if (!envAdd && volume != '0)  volume <= volume - 4'd1;
      end else begin
        env_timer <= env_timer - 3'd1;
      end
    end
  end

  // Divider at 0 means parked since reset: the LFSR holds 7FFF until the
  // first trigger loads a period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      lfsr    <= '1;
    end else if (trigger) begin
      div_cnt <= div_reload;
      lfsr    <= '1;
    end else if (div_cnt == DIV_W'(1)) begin
      div_cnt <= div_reload;
      if (lfsr_run) lfsr <= lfsr_next;
    end else if (div_cnt != '0) begin
      div_cnt <= div_cnt - DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out <= '0;
    else     out <= (enabled && !lfsr[0]) ? volume : '0;
  end

endmodule

// File: tb/tb_noise_channel.sv
module tb_noise_channel;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk256 = 1'b0, clk64 = 1'b0;
  logic [5:0] lenLoad = '0;
  logic [3:0] startVol = '0;
  logic       envAdd = 1'b0;
  logic [2:0] period = '0;
  logic [3:0] clkShift = '0;
  logic       widthMode = 1'b0;
  logic [2:0] divisor = '0;
  logic       trigger = 1'b0;
  logic       lenEnable = 1'b0;
  logic [3:0] out;

  noise_channel dut (
    .clk(clk), .rst(rst), .clk256(clk256), .clk64(clk64),
    .lenLoad(lenLoad), .startVol(startVol), .envAdd(envAdd), .period(period),
    .clkShift(clkShift), .widthMode(widthMode), .divisor(divisor),
    .trigger(trigger), .lenEnable(lenEnable), .out(out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  string phase = "reset";

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model, stepped once per rising clock edge.
  int base [8] = '{8, 16, 32, 48, 64, 80, 96, 112};
  int m_out, m_en, m_vol, m_len, m_etmr, m_div, m_lfsr, p256, p64;

  function automatic int lfsr_step(input int v, input bit short_m);
    int x;
    x = (v ^ (v >> 1)) & 1;
    v = (v >> 1) | (x << 14);
    if (short_m) v = (v & ~(1 << 6)) | (x << 6);
    return v;
  endfunction

  task automatic model_reset();
    m_out = 0; m_en = 0; m_vol = 0; m_len = 0; m_etmr = 0; m_div = 0;
    m_lfsr = 'h7FFF; p256 = 0; p64 = 0;
  endtask

  task automatic model_step();
    bit r256, r64, dac;
    int reload;
    r256 = clk256 && !p256;
    r64  = clk64 && !p64;
    p256 = clk256;
    p64  = clk64;
    dac  = (startVol != 0) || envAdd;
    reload = base[divisor] * (1 << clkShift);
    m_out = (m_en != 0 && (m_lfsr % 2) == 0) ? m_vol : 0;
    if (trigger) begin
      m_en = dac; m_len = 64 - int'(lenLoad); m_vol = startVol;
      m_etmr = period; m_lfsr = 'h7FFF; m_div = reload;
    end else begin
      if (r256 && lenEnable && m_len > 0) begin
        m_len--;
        if (m_len == 0) m_en = 0;
      end
      if (r64 && period != 0) begin
        if (m_etmr <= 1) begin
          m_etmr = period;
          if (envAdd) m_vol = (m_vol < 15) ? m_vol + 1 : 15;
          else        m_vol = (m_vol > 0) ? m_vol - 1 : 0;
        end else m_etmr--;
      end
      if (m_div == 1) begin
        m_div = reload;
        if (clkShift < 14) m_lfsr = lfsr_step(m_lfsr, widthMode);
      end else if (m_div > 0) m_div--;
    end
    if (!dac) m_en = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (!rst) model_step();
      @(negedge clk);
      check({phase, "_out"}, out, m_out);
      check({phase, "_lfsr"}, dut.lfsr, m_lfsr);
    end
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1; run(1); trigger = 1'b0;
  endtask

  task automatic tick256_pulse();
    clk256 = 1'b1; run(3); clk256 = 1'b0; run(3);
  endtask

  task automatic tick64_pulse();
    clk64 = 1'b1; run(3); clk64 = 1'b0; run(20);
  endtask

  initial begin
    model_reset();
    run(5);
    check("reset_out", out, 0);
    rst = 1'b0;

    phase = "idle";
    run(1000);
    check("idle_lfsr", dut.lfsr, 'h7FFF);
    check("idle_out", out, 0);

    phase = "tone";
    startVol = 4'd15;
    pulse_trigger();
    run(7);
    check("tone_pre_step", dut.lfsr, 'h7FFF);
    run(1);
    check("tone_first_step", dut.lfsr, 'h3FFF);
    check("tone_first_out", out, 0);
    run(2000);

    phase = "short";
    widthMode = 1'b1;
    pulse_trigger();
    run(2100);
    widthMode = 1'b0;

    phase = "len_on";
    lenLoad = 6'd62; lenEnable = 1'b1;
    pulse_trigger();
    run(130);
    tick256_pulse();
    tick256_pulse();
    check("len_en_after2", dut.enabled, 0);
    for (int i = 0; i < 40; i++) begin
      run(1);
      check("len_off_out", out, 0);
    end

    phase = "len_dis";
    lenEnable = 1'b0;
    pulse_trigger();
    run(20);
    tick256_pulse(); tick256_pulse(); tick256_pulse();
    check("len_dis_en", dut.enabled, 1);
    run(150);

    phase = "env_down";
    startVol = 4'd2; envAdd = 1'b0; period = 3'd1;
    pulse_trigger();
    run(130);
    for (int i = 0; i < 4; i++) tick64_pulse();
    check("env_down_vol", dut.volume, 0);
    run(100);

    phase = "env_up";
    startVol = 4'd14; envAdd = 1'b1;
    pulse_trigger();
    run(130);
    for (int i = 0; i < 3; i++) tick64_pulse();
    check("env_up_vol", dut.volume, 15);
    run(100);

    phase = "dac_off";
    startVol = 4'd0; envAdd = 1'b0; period = 3'd0;
    pulse_trigger();
    for (int i = 0; i < 200; i++) begin
      run(1);
      check("dac_off_out", out, 0);
    end
    check("dac_off_en", dut.enabled, 0);

    phase = "prio";
    startVol = 4'd15; lenEnable = 1'b1; lenLoad = 6'd63;
    pulse_trigger();
    run(5);
    lenLoad = 6'd60; clk256 = 1'b1; trigger = 1'b1;
    run(1);
    trigger = 1'b0;
    run(2);
    clk256 = 1'b0;
    check("prio_en", dut.enabled, 1);
    check("prio_count", dut.u_len.count, 4);
    run(150);

    phase = "shift14";
    clkShift = 4'd14;
    pulse_trigger();
    run(300);
    check("shift14_lfsr", dut.lfsr, 'h7FFF);

    phase = "random";
    clkShift = 4'd0;
    for (int i = 0; i < 4000; i++) begin
      trigger = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0) clk256 = ~clk256;
      if ($urandom_range(0, 11) == 0) clk64 = ~clk64;
      if ($urandom_range(0, 59) == 0) begin
        lenLoad   = 6'($urandom_range(0, 63));
        startVol  = 4'($urandom_range(0, 15));
        envAdd    = 1'($urandom_range(0, 1));
        period    = 3'($urandom_range(0, 7));
        divisor   = 3'($urandom_range(0, 7));
        widthMode = 1'($urandom_range(0, 1));
        lenEnable = 1'($urandom_range(0, 1));
        clkShift  = ($urandom_range(0, 7) == 0) ? 4'd14 : 4'($urandom_range(0, 2));
      end
      if (i == 2000) begin
        rst = 1'b1;
        model_reset();
        #1;
        check("mid_rst_out", out, 0);
        check("mid_rst_lfsr", dut.lfsr, 'h7FFF);
        run(3);
        rst = 1'b0;
      end
      run(1);
    end
    trigger = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
